debug_cmd_sequencer: RTL and testbench

//  Script-driven command engine for the debug-unit UART link. It replays a stored

---
 rtl/debug_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_debug_cmd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_sequencer.sv
// Script-driven command engine for the debug UART link: replays stored tx bytes,
// waits on real tx/rx handshakes, forwards response bytes and flags timeouts.
module debug_cmd_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int SCRIPT_DEPTH   = 64,
    parameter int NB_ADDR        = 6,
    parameter int NB_RXCNT       = 8,
    parameter int NB_TMO         = 20,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_wr_en,
    input  logic [NB_ADDR-1:0]           i_wr_addr,
    input  logic [NB_RXCNT+NB_DATA-1:0]  i_wr_data,
    input  logic                         i_start,
    input  logic [NB_ADDR:0]             i_length,
    input  logic                         i_abort,
    output logic [NB_DATA-1:0]           o_tx_data,
    output logic                         o_tx_start,
    input  logic                         i_tx_done_tick,
    input  logic [NB_DATA-1:0]           i_rx_data,
    input  logic                         i_rx_done_tick,
    output logic [NB_DATA-1:0]           o_rsp_data,
    output logic                         o_rsp_valid,
    output logic [NB_ADDR-1:0]           o_rsp_idx,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_error,
    output logic [1:0]                   o_err_code,
    output logic [NB_ADDR-1:0]           o_err_addr,
    output logic [2:0]                   o_state
);

    localparam int                NB_ENTRY  = NB_RXCNT + NB_DATA;
    localparam logic [NB_ADDR:0]  DEPTH_LEN = (NB_ADDR+1)'(SCRIPT_DEPTH);
    localparam logic [NB_TMO-1:0] TMO_LAST  = NB_TMO'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_TX = 3'd3,
        ST_WAIT_RX = 3'd4,
        ST_ADV     = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    state_t              state, state_next;
    logic [NB_ENTRY-1:0] script_mem [SCRIPT_DEPTH];
    logic [NB_ENTRY-1:0] entry_q;
    logic [NB_ADDR-1:0]  idx;
    logic [NB_ADDR:0]    len_q;
    logic [NB_ADDR:0]    len_sat;
    logic [NB_RXCNT-1:0] rx_left;
    logic [NB_DATA-1:0]  tx_data_q;
    logic [NB_TMO-1:0]   tmo_cnt;
    logic                busy, waiting, start_ok, tx_accept, rx_accept, rx_last;
    logic                tmo_hit, last_entry, done_set;

    assign busy       = (state == ST_FETCH) || (state == ST_SEND) || (state == ST_WAIT_TX) ||
                        (state == ST_WAIT_RX) || (state == ST_ADV);
    assign waiting    = (state == ST_WAIT_TX) || (state == ST_WAIT_RX);
    assign start_ok   = i_start && !busy && !i_abort;
    assign len_sat    = (i_length > DEPTH_LEN) ? DEPTH_LEN : i_length;
    assign tx_accept  = i_tx_done_tick && (state == ST_WAIT_TX) && !i_abort;
    assign rx_accept  = i_rx_done_tick && waiting && (rx_left != '0) && !i_abort;
    assign rx_last    = rx_accept && (rx_left == NB_RXCNT'(1));
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign last_entry = ({1'b0, idx} == (len_q - 1'b1));

    // Abort wins over everything; an accepted tick in the same cycle defeats a timeout.
    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        if (i_abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok) begin
                        if (len_sat == '0) begin
                            state_next = ST_DONE;
                            done_set   = 1'b1;
                        end else begin
                            state_next = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: state_next = ST_SEND;
                ST_SEND:  state_next = ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (tx_accept)
                        state_next = ((rx_left == '0) || rx_last) ? ST_ADV : ST_WAIT_RX;
                    else if (!rx_accept && tmo_hit)
                        state_next = ST_ERROR;
                end
                ST_WAIT_RX: begin
                    if (rx_last)
                        state_next = ST_ADV;
                    else if (!rx_accept && tmo_hit)
                        state_next = ST_ERROR;
                end
                ST_ADV: begin
                    if (last_entry) begin
                        state_next = ST_DONE;
                        done_set   = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            len_q       <= '0;
            rx_left     <= '0;
            tx_data_q   <= '0;
            tmo_cnt     <= '0;
            o_done      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_idx   <= '0;
            o_err_code  <= 2'b00;
            o_err_addr  <= '0;
        end else begin
            state       <= state_next;
            o_done      <= done_set;
            o_rsp_valid <= rx_accept;
            if (start_ok && (len_sat != '0)) begin
                idx        <= '0;
                len_q      <= len_sat;
                o_err_code <= 2'b00;
                o_err_addr <= '0;
            end
            if (state == ST_SEND) begin
                tx_data_q <= entry_q[NB_DATA-1:0];
                rx_left   <= entry_q[NB_ENTRY-1:NB_DATA];
            end
            if (rx_accept) begin
                o_rsp_data <= i_rx_data;
                o_rsp_idx  <= idx;
                rx_left    <= rx_left - 1'b1;
            end
            if ((state == ST_ADV) && !last_entry)
                idx <= idx + 1'b1;
            if ((state_next == ST_ERROR) && (state != ST_ERROR)) begin
                o_err_code <= (state == ST_WAIT_TX) ? 2'b01 : 2'b10;
                o_err_addr <= idx;
            end
            if ((state_next != state) || rx_accept || !waiting)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Script RAM keeps its contents across reset and is frozen while a script runs.
    always_ff @(posedge i_clock) begin
        if (i_wr_en && !busy)
            script_mem[i_wr_addr] <= i_wr_data;
        entry_q <= script_mem[idx];
    end

    assign o_tx_start = (state == ST_SEND);
    assign o_tx_data  = (state == ST_SEND) ? entry_q[NB_DATA-1:0] : tx_data_q;
    assign o_busy     = busy;
    assign o_error    = (state == ST_ERROR);
    assign o_state    = state;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Scoreboard bench for debug_cmd_sequencer with a simple UART model that acks
// each tx byte after a fixed delay and optionally replies to one command byte.
`timescale 1ns/1ps
module tb_debug_cmd_sequencer;

    localparam int NB_DATA = 8, SCRIPT_DEPTH = 64, NB_ADDR = 6, NB_RXCNT = 8;
    localparam int NB_TMO = 20, TMO = 1000;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        wr_en;
    logic [NB_ADDR-1:0]          wr_addr;
    logic [NB_RXCNT+NB_DATA-1:0] wr_data;
    logic                        start;
    logic [NB_ADDR:0]            length;
    logic                        abort;
    logic [NB_DATA-1:0]          tx_data;
    logic                        tx_start;
    logic                        tx_done_tick;
    logic [NB_DATA-1:0]          rx_data;
    logic                        rx_done_tick;
    logic [NB_DATA-1:0]          rsp_data;
    logic                        rsp_valid;
    logic [NB_ADDR-1:0]          rsp_idx;
    logic                        busy, done, error;
    logic [1:0]                  err_code;
    logic [NB_ADDR-1:0]          err_addr;
    logic [2:0]                  state;

    int n_checks = 0, n_errors = 0;
    int tx_cnt = 0, done_cnt = 0, rsp_cnt = 0;
    int ack_delay = 100;
    logic [7:0]  exp_tx_q[$];
    logic [13:0] exp_rsp_q[$];
    logic [7:0]  reply_q[$];
    logic [7:0]  reply_cmd = 8'h06;
    logic [5:0]  reply_idx = '0;

    always #5 clk = ~clk;

    debug_cmd_sequencer #(
        .NB_DATA(NB_DATA), .SCRIPT_DEPTH(SCRIPT_DEPTH), .NB_ADDR(NB_ADDR),
        .NB_RXCNT(NB_RXCNT), .NB_TMO(NB_TMO), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start), .i_length(length), .i_abort(abort),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done_tick(tx_done_tick),
        .i_rx_data(rx_data), .i_rx_done_tick(rx_done_tick), .o_rsp_data(rsp_data),
        .o_rsp_valid(rsp_valid), .o_rsp_idx(rsp_idx), .o_busy(busy), .o_done(done),
        .o_error(error), .o_err_code(err_code), .o_err_addr(err_addr), .o_state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every tx request and response pulse.
    always @(negedge clk) begin
        if (tx_start) begin
            tx_cnt++;
            if (exp_tx_q.size() == 0) check("tx_unexpected", 1, 0);
            else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
        end
        if (rsp_valid) begin
            rsp_cnt++;
            if (exp_rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_idx_data", {18'd0, rsp_idx, rsp_data}, {18'd0, exp_rsp_q.pop_front()});
        end
        if (done) done_cnt++;
    end

    // UART model: ack after ack_delay cycles, then reply with reply_q if the byte matches.
    initial begin : uart_model
        logic [7:0] cmd;
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = '0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                cmd = tx_data;
                repeat (ack_delay - 1) @(negedge clk);
                tx_done_tick = 1'b1;
                @(negedge clk);
                tx_done_tick = 1'b0;
                if (cmd == reply_cmd) begin
                    while (reply_q.size() > 0) begin
                        repeat (3) @(negedge clk);
                        rx_data      = reply_q.pop_front();
                        rx_done_tick = 1'b1;
                        exp_rsp_q.push_back({reply_idx, rx_data});
                        @(negedge clk);
                        rx_done_tick = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic write_entry(input int addr, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 6'(addr);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        length = 7'(len);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_state_reached"}, {29'd0, state}, {29'd0, s});
    endtask

    initial begin
        int d0, t0, r0, cyc;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; length = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", {29'd0, state}, 0);
        check("rst_ctrl", {27'd0, busy, tx_start, done, error, rsp_valid}, 0);
        check("rst_data", {8'd0, tx_data, rsp_data, 2'b0, rsp_idx}, 0);
        check("rst_err", {24'd0, err_code, err_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: 41-entry script with no responses
        write_entry(0, {8'd0, 8'h01});
        exp_tx_q.push_back(8'h01);
        for (int i = 1; i <= 40; i++) begin
            write_entry(i, {8'd0, 8'h80 | 8'(i)});
            exp_tx_q.push_back(8'h80 | 8'(i));
        end
        d0 = done_cnt; t0 = tx_cnt;
        pulse_start(41);
        wait_done(d0, 6000, "t1");
        repeat (5) @(negedge clk);
        check("t1_tx_count", 32'(tx_cnt - t0), 41);
        check("t1_tx_left", 32'(exp_tx_q.size()), 0);
        check("t1_single_done", 32'(done_cnt - d0), 1);
        check("t1_state_done", {29'd0, state}, 6);
        check("t1_no_error", {31'd0, error}, 0);
        check("t1_not_busy", {31'd0, busy}, 0);

        // Test 2: middle entry collects four response bytes
        write_entry(0, {8'd0, 8'h01});
        write_entry(1, {8'd4, 8'h06});
        write_entry(2, {8'd0, 8'h07});
        reply_idx = 6'd1;
        reply_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_tx_q = '{8'h01, 8'h06, 8'h07};
        d0 = done_cnt; r0 = rsp_cnt;
        pulse_start(3);
        wait_done(d0, 1500, "t2");
        repeat (3) @(negedge clk);
        check("t2_rsp_count", 32'(rsp_cnt - r0), 4);
        check("t2_rsp_left", 32'(exp_rsp_q.size()), 0);
        check("t2_tx_left", 32'(exp_tx_q.size()), 0);

        // Test 3: rx timeout on entry 1
        write_entry(1, {8'd4, 8'h06});
        exp_tx_q = '{8'h01, 8'h06};
        pulse_start(2);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (!(tx_done_tick && tx_data == 8'h06) && cyc < 1000);
        check("t3_tx_done_seen", {31'd0, tx_done_tick}, 1);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (state != 3'd7 && cyc < 2000);
        check("t3_timeout_cycles", 32'(cyc), 1000);
        @(negedge clk);
        check("t3_error", {31'd0, error}, 1);
        check("t3_err_code", {30'd0, err_code}, 2);
        check("t3_err_addr", {26'd0, err_addr}, 1);
        check("t3_not_busy", {31'd0, busy}, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_abort_idle", {29'd0, state}, 0);

        // Test 4: abort in WAIT_RX, then replay from index 0
        write_entry(0, {8'd2, 8'h06});
        reply_idx = 6'd0;
        exp_tx_q = '{8'h06};
        d0 = done_cnt;
        pulse_start(1);
        wait_state(3'd4, 300, "t4_wait_rx");
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_busy", {31'd0, busy}, 0);
        check("t4_abort_state", {29'd0, state}, 0);
        repeat (20) @(negedge clk);
        check("t4_no_done", 32'(done_cnt - d0), 0);
        reply_q = '{8'h11, 8'h22};
        exp_tx_q = '{8'h06};
        d0 = done_cnt; r0 = rsp_cnt;
        pulse_start(1);
        wait_done(d0, 500, "t4_replay");
        repeat (3) @(negedge clk);
        check("t4_rsp_count", 32'(rsp_cnt - r0), 2);
        check("t4_tx_left", 32'(exp_tx_q.size()), 0);

        // Test 5: zero length, and writes ignored while busy
        t0 = tx_cnt;
        @(negedge clk);
        length = '0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("t5_done_pulse", {31'd0, done}, 1);
        check("t5_state_done", {29'd0, state}, 6);
        repeat (3) @(negedge clk);
        check("t5_done_low", {31'd0, done}, 0);
        check("t5_no_tx", 32'(tx_cnt - t0), 0);
        write_entry(0, {8'd0, 8'h33});
        exp_tx_q = '{8'h33};
        d0 = done_cnt;
        pulse_start(1);
        write_entry(0, {8'd0, 8'h99});
        wait_done(d0, 500, "t5_run");
        exp_tx_q.push_back(8'h33);
        d0 = done_cnt;
        pulse_start(1);
        wait_done(d0, 500, "t5_readback");
        repeat (3) @(negedge clk);
        check("t5_tx_left", 32'(exp_tx_q.size()), 0);

        // Test 6: async reset mid WAIT_TX, then clean rerun
        write_entry(0, {8'd0, 8'h41});
        write_entry(1, {8'd0, 8'h42});
        exp_tx_q = '{8'h41, 8'h42};
        pulse_start(2);
        wait_state(3'd3, 100, "t6_wait_tx");
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_state", {29'd0, state}, 0);
        check("t6_rst_ctrl", {27'd0, busy, tx_start, done, error, rsp_valid}, 0);
        check("t6_rst_data", {16'd0, tx_data, rsp_data}, 0);
        check("t6_pending_tx", 32'(exp_tx_q.size()), 1);
        exp_tx_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        exp_tx_q = '{8'h41, 8'h42};
        d0 = done_cnt;
        pulse_start(2);
        wait_done(d0, 600, "t6_rerun");
        repeat (3) @(negedge clk);
        check("t6_tx_left", 32'(exp_tx_q.size()), 0);
        check("t6_no_error", {31'd0, error}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
